// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO push port; FIFO_ARB_STATS_EN adds per-requester beat counters
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int W_DATA    = 8,
    parameter int MAX_BURST = 4,
    localparam int GW = (N_REQ > 2) ? $clog2(N_REQ) : 1,
    localparam int CW = $clog2(MAX_BURST + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*W_DATA-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_push,
    output logic [W_DATA-1:0]         fifo_data,
    output logic [GW-1:0]             grant_id,
`ifdef FIFO_ARB_STATS_EN
    output logic                      grant_valid,
    input  logic                      stat_clr,
    output logic [N_REQ*16-1:0]       stat_cnt
`else
    output logic                      grant_valid
`endif
);
    typedef enum logic {IDLE, BURST} state_t;
    state_t          state;
    logic [GW-1:0]   rr_ptr, owner, win, sel, idx;
    logic [GW:0]     sum;
    logic [CW-1:0]   burst_cnt;
    logic            win_found, push;
    logic [W_DATA-1:0] data_arr [N_REQ];

    function automatic logic [GW-1:0] nxt(input logic [GW-1:0] x);
        return (x == GW'(N_REQ - 1)) ? '0 : x + 1'b1;
    endfunction

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign data_arr[i] = req_data[i*W_DATA +: W_DATA];
    end

    // Winner is the first valid requester at or after rr_ptr, wrapping by compare
    always_comb begin
        win_found = 1'b0;
        win = '0;
        sum = '0;
        idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + (GW+1)'(k);
            idx = (sum >= (GW+1)'(N_REQ)) ? GW'(sum - (GW+1)'(N_REQ)) : GW'(sum);
            if (req_valid[idx]) begin
                win_found = 1'b1;
                win = idx;
            end
        end
    end

    assign sel  = (state == BURST) ? owner : win;
    assign push = rst_n && !fifo_full && ((state == BURST) ? req_valid[sel] : win_found);

    // Zero-latency FIFO write side; ready goes only to the selected requester
    always_comb begin
        req_ready = '0;
        if (rst_n && !fifo_full && (state == BURST || win_found)) req_ready[sel] = 1'b1;
        fifo_push   = push;
        grant_valid = push;
        grant_id    = push ? sel : '0;
        fifo_data   = push ? data_arr[sel] : '0;
    end

    // Sequencing: grant in IDLE, stream in BURST until max length or owner drops valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            burst_cnt <= '0;
        end else if (state == IDLE) begin
            if (push) begin
                if (MAX_BURST == 1) begin
                    rr_ptr <= nxt(win);
                end else begin
                    state     <= BURST;
                    owner     <= win;
                    burst_cnt <= CW'(1);
                end
            end
        end else if (!req_valid[owner] || (push && burst_cnt == CW'(MAX_BURST - 1))) begin
            state     <= IDLE;
            rr_ptr    <= nxt(owner);
            burst_cnt <= '0;
        end else if (push) begin
            burst_cnt <= burst_cnt + 1'b1;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    for (genvar i = 0; i < N_REQ; i++) begin : g_stat
        logic [15:0] cnt;
        // Saturating accepted-beat counter; clear beats a same-cycle push
        always_ff @(posedge clk) begin
            if (!rst_n || stat_clr) cnt <= '0;
            else if (push && grant_id == GW'(i) && cnt != 16'hFFFF) cnt <= cnt + 1'b1;
        end
        assign stat_cnt[i*16 +: 16] = cnt;
    end
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: randomized and directed bench with a behavioural round-robin burst model
module tb_fifo_wr_arbiter;
    localparam int N = 4, W = 8, MB = 4;

    logic             clk = 1'b0, rst_n = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N*W-1:0]   req_data = '0;
    logic             fifo_full = 1'b0;
    logic [N-1:0]     req_ready;
    logic             fifo_push, grant_valid;
    logic [W-1:0]     fifo_data;
    logic [1:0]       grant_id;
`ifdef FIFO_ARB_STATS_EN
    logic             stat_clr = 1'b0;
    logic [N*16-1:0]  stat_cnt;
`endif

    fifo_wr_arbiter #(.N_REQ(N), .W_DATA(W), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_push(fifo_push),
        .fifo_data(fifo_data), .grant_id(grant_id),
`ifdef FIFO_ARB_STATS_EN
        .grant_valid(grant_valid), .stat_clr(stat_clr), .stat_cnt(stat_cnt)
`else
        .grant_valid(grant_valid)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0, n_acc = 0, n_push = 0;
    logic [7:0] src_mem [N][256];
    int head [N], tail [N];
    logic [N-1:0] refill = '0;
    bit en_rand = 1'b0;
    int log_id[$], log_data[$], log_cyc[$];

    // model: who holds the grant, how many beats so far, where the next search starts
    bit m_busy = 1'b0;
    int m_own = 0, m_beats = 0, m_ptr = 0;
    int e_id, e_ready;
    bit e_push;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic enq(input int i, input logic [7:0] d);
        src_mem[i][tail[i] % 256] = d;
        tail[i]++;
    endtask

    task automatic tick;
        logic [N-1:0] acc;
        logic hold;
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                head[i]++;
                n_acc++;
            end
            if (refill[i] && tail[i] - head[i] < 4) enq(i, 8'($urandom));
            hold = req_valid[i] && !acc[i];
            req_valid[i] = hold || (tail[i] > head[i] && (!en_rand || $urandom_range(3) != 0));
            req_data[i*W +: W] = req_valid[i] ? src_mem[i][head[i] % 256] : 8'h00;
        end
    endtask

    task automatic restart;
        rst_n = 1'b0;
        fifo_full = 1'b0;
        req_valid = '0;
        req_data = '0;
        refill = '0;
        en_rand = 1'b0;
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        tick;
        tick;
        rst_n = 1'b1;
        log_id.delete();
        log_data.delete();
        log_cyc.delete();
    endtask

    // compare DUT against the model every cycle, then advance the model
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            chk("rst_ready", 32'(req_ready), 0);
            chk("rst_push", 32'(fifo_push), 0);
            chk("rst_gvalid", 32'(grant_valid), 0);
            chk("rst_gid", 32'(grant_id), 0);
            chk("rst_data", 32'(fifo_data), 0);
            m_busy = 1'b0;
            m_ptr = 0;
            m_beats = 0;
        end else begin
            e_ready = 0;
            if (!m_busy) begin
                e_id = -1;
                for (int k = N - 1; k >= 0; k--) if (req_valid[(m_ptr + k) % N]) e_id = (m_ptr + k) % N;
                e_push = !fifo_full && e_id >= 0;
                if (e_push) e_ready = 1 << e_id;
            end else begin
                e_id = m_own;
                e_push = req_valid[m_own] && !fifo_full;
                if (!fifo_full) e_ready = 1 << m_own;
            end
            chk("push", 32'(fifo_push), 32'(e_push));
            chk("grant_valid", 32'(grant_valid), 32'(e_push));
            chk("ready", 32'(req_ready), e_ready);
            if (e_push) begin
                chk("grant_id", 32'(grant_id), e_id);
                chk("fifo_data", 32'(fifo_data), 32'(req_data[e_id*W +: W]));
            end
            if (fifo_push) begin
                log_id.push_back(int'(grant_id));
                log_data.push_back(int'(fifo_data));
                log_cyc.push_back(cyc);
                n_push++;
            end
            if (!m_busy) begin
                if (e_push) begin
                    if (MB == 1) m_ptr = (e_id + 1) % N;
                    else begin
                        m_busy = 1'b1;
                        m_own = e_id;
                        m_beats = 1;
                    end
                end
            end else if (!req_valid[m_own]) begin
                m_busy = 1'b0;
                m_ptr = (m_own + 1) % N;
            end else if (e_push) begin
                m_beats++;
                if (m_beats == MB) begin
                    m_busy = 1'b0;
                    m_ptr = (m_own + 1) % N;
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
            for (int k = 0; k < 8; k++) enq(i, 8'(i*16 + k));
        end
        // reset held with every requester valid
        repeat (4) tick;
        chk("rst_hold_ready", 32'(req_ready), 0);
        chk("rst_hold_valid", 32'(req_valid), 32'hF);
        rst_n = 1'b1;
        log_id.delete();
        log_data.delete();
        log_cyc.delete();
        repeat (17) tick;
        chk("rr_count", log_id.size(), 17);
        for (int k = 0; k < 17; k++) chk("rr_id", log_id[k], (k % 16) / 4);
        chk("rr_data4", log_data[4], 32'h10);
        chk("rr_data16", log_data[16], 32'h04);
        chk("rr_no_idle", log_cyc[16] - log_cyc[0], 16);

        // early release by requester 2
        restart;
        enq(2, 8'hA0);
        enq(2, 8'hA1);
        repeat (5) tick;
        chk("er_count", log_id.size(), 2);
        chk("er_d0", log_data[0], 32'hA0);
        chk("er_d1", log_data[1], 32'hA1);
        chk("er_id", log_id[1], 2);
        chk("er_model_idle", 32'(m_busy), 0);
        chk("er_model_ptr", m_ptr, 3);
        for (int i = 0; i < N; i++) enq(i, 8'(8'hB0 + i));
        repeat (3) tick;
        chk("er_next_id", log_id[2], 3);

        // fifo_full for three cycles in the middle of requester 1's burst
        restart;
        for (int k = 0; k < 4; k++) enq(1, 8'(8'h10 + k));
        enq(2, 8'h20);
        repeat (3) tick;
        fifo_full = 1'b1;
        repeat (3) tick;
        chk("fm_stall_count", log_id.size(), 2);
        chk("fm_stall_ready", 32'(req_ready), 0);
        fifo_full = 1'b0;
        repeat (4) tick;
        chk("fm_count", log_id.size(), 5);
        for (int k = 0; k < 4; k++) begin
            chk("fm_data", log_data[k], 32'h10 + k);
            chk("fm_id", log_id[k], 1);
        end
        chk("fm_next", log_id[4], 2);
        chk("fm_next_data", log_data[4], 32'h20);
        chk("fm_stall_gap", log_cyc[2] - log_cyc[1], 4);
        chk("fm_no_bubble", log_cyc[4] - log_cyc[3], 1);

        // full while idle, then reset during requester 3's burst
        restart;
        for (int i = 0; i < N; i++) for (int k = 0; k < 8; k++) enq(i, 8'(8'h40 + i*16 + k));
        fifo_full = 1'b1;
        repeat (4) tick;
        chk("fi_no_grant", log_id.size(), 0);
        fifo_full = 1'b0;
        repeat (13) tick;
        chk("fi_count", log_id.size(), 13);
        chk("fi_first", log_id[0], 0);
        chk("fi_last", log_id[12], 3);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        log_id.delete();
        tick;
        chk("fi_after_rst", log_id.size(), 1);
        chk("fi_after_rst_id", log_id[0], 0);

        // randomized traffic, backpressure and occasional reset
        restart;
        refill = '1;
        en_rand = 1'b1;
        n_acc = 0;
        n_push = 0;
        repeat (3000) begin
            fifo_full = ($urandom_range(3) == 0);
            rst_n = ($urandom_range(299) != 0);
            tick;
        end
        rst_n = 1'b1;
        fifo_full = 1'b0;
        chk("rand_beats", n_acc, n_push);

`ifdef FIFO_ARB_STATS_EN
        restart;
        refill = 4'b0001;
        repeat (70005) tick;
        chk("stat_sat", 32'(stat_cnt[15:0]), 32'hFFFF);
        chk("stat_others", 32'(|stat_cnt[N*16-1:16]), 0);
        stat_clr = 1'b1;
        tick;
        stat_clr = 1'b0;
        chk("stat_clr", 32'(stat_cnt[15:0]), 0);
        tick;
        chk("stat_after_clr", 32'(stat_cnt[15:0]), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that shares the single push port of the team's 16-deep, 8-bit FIFO among N_REQ producers.
- Sits between the producer blocks and the FIFO write side.
- Grants bursts of up to MAX_BURST beats per requester, honours fifo_full, and drives the FIFO push/data inputs combinationally (zero-latency handshake).
- Holds all sequencing state: round-robin pointer, burst owner, burst counter.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- W_DATA, 8, data width, matches FIFO data_t
- MAX_BURST, 4, max consecutive beats per grant (1..16)

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- req_valid  input  N_REQ  per-requester data valid
- req_data  input  N_REQ*W_DATA  requester i data at [i*W_DATA +: W_DATA]
- req_ready  output  N_REQ  per-requester accept; beat transfers when valid&ready
- fifo_full  input  1  FIFO full flag
- fifo_push  output  1  push strobe (PUSH=1/NO_PUSH=0)
- fifo_data  output  W_DATA  data to FIFO
- grant_id  output  max(1,$clog2(N_REQ))  index of requester pushing this cycle
- grant_valid  output  1  high in any cycle fifo_push is high

Behaviour:
- Reset: rst_n sampled low at clk edge -> state=IDLE, rr_ptr=0, owner=0, burst_cnt=0. Reset dominates every other event, including mid-burst.
- Outputs are combinational from state and inputs. While rst_n is low they are forced to req_ready=0, fifo_push=0, fifo_data=0, grant_id=0, grant_valid=0.
- States: IDLE, BURST.
- IDLE, winner selection: the winner is the first requester with req_valid=1, searching rr_ptr, rr_ptr+1, ... mod N_REQ.
- IDLE with fifo_full=0 and a winner w:
  - Same cycle: req_ready[w]=1, fifo_push=1, fifo_data=req_data[w], grant_id=w.
  - If MAX_BURST=1: stay IDLE, rr_ptr<=(w+1) mod N_REQ.
  - Else: go to BURST, owner<=w, burst_cnt<=1.
- IDLE with fifo_full=1 or no valid requester: no push, all ready=0, rr_ptr unchanged.
- BURST, outputs: req_ready[owner]=~fifo_full; all other ready=0.
- BURST, push: when req_valid[owner]=1 and fifo_full=0, push req_data[owner] and burst_cnt<=burst_cnt+1.
- BURST, max-burst exit: if that push makes burst_cnt==MAX_BURST -> IDLE, rr_ptr<=(owner+1) mod N_REQ. IDLE arbitrates in the next cycle with no bubble.
- BURST, release: if req_valid[owner]=0 -> no push this cycle, IDLE, rr_ptr<=(owner+1) mod N_REQ. This costs one bubble cycle.
- BURST, fifo_full=1 with valid high: stall. No push, state, burst_cnt and owner held, no beat lost or duplicated.
- burst_cnt width is $clog2(MAX_BURST+1). It never exceeds MAX_BURST and is cleared on entry to IDLE.
- rr_ptr wrap: N_REQ-1 -> 0. Non-power-of-2 N_REQ is supported via explicit compare.
- Invariant: fifo_push=1 only when fifo_full=0. At most one bit of req_ready is high.
- Producers must hold req_data stable while req_valid=1 and ready=0.

Optional Feature:
- Macro: FIFO_ARB_STATS_EN.
- When defined, two ports are added:
  - stat_clr  input  1  synchronous clear
  - stat_cnt  output  N_REQ*16  per-requester 16-bit accepted-beat counters
- Counter behaviour:
  - Counter i increments on every push with grant_id=i and saturates at 16'hFFFF.
  - stat_clr=1 zeroes all counters; clear wins over a same-cycle push.
  - Counters are reset to 0 by rst_n.
- When not defined: ports and logic are absent; arbitration behaviour is identical.

Test Plan:
- Reset: rst_n=0 for 3 cycles with req_valid=4'hF -> fifo_push=0 and req_ready=0 each cycle. After release, first push has grant_id=0.
- Full round-robin: req_valid=4'hF, fifo_full=0, MAX_BURST=4 -> 16 consecutive pushes with grant_id 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3, then 0 again. No idle cycle.
- Early release: only req 2 valid, sending 0xA0, 0xA1, then valid drops -> exactly 2 pushes (0xA0, 0xA1), one no-push cycle, state IDLE, rr_ptr=3.
- Full mid-burst: req 1 streams 0x10..0x13, fifo_full=1 for 3 cycles after the 2nd beat -> push=0 and req_ready[1]=0 during full. FIFO receives 0x10, 0x11, 0x12, 0x13 exactly once, then grant moves to req 2.
- Full in IDLE plus mid-burst reset: fifo_full=1 with all valid -> no grant, rr_ptr unchanged. Then rst_n=0 during req 3 burst -> next grant goes to req 0.
- Stats (FIFO_ARB_STATS_EN): 70000 beats from req 0 -> stat_cnt[15:0]=16'hFFFF. stat_clr=1 on a push cycle -> 0.
